systolic_tile_os: RTL
=====================

Name: systolic_tile_os

Overview:
Parameterised output-stationary integer systolic tile: ROWS x COLS MAC grid with built-in input skew, a K-length accumulation sequencer, and a row-serial result drain. It extends the free-running PE array with valid/ready streaming, stall-safe advance, K-tiling accumulation (acc_keep) and a signed/unsigned mode. It sits between the operand buffers and the result writeback of the expert compute path.

Parameters:
DATA_W, 16, operand width (in_a and in_b elements)
ACC_W, 40, accumulator width; wraps modulo 2^ACC_W
ROWS, 4, grid height (A lanes, output rows)
COLS, 4, grid width (B lanes, output columns)
KLEN_W, 16, width of k_len
ROW_IDX_W, max(1,$clog2(ROWS)), width of out_row_idx

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
start  in  1  one-cycle job request; honoured only in IDLE
k_len  in  KLEN_W  vectors to accumulate; sampled with start
acc_keep  in  1  sampled with start: 1 = keep accumulators, 0 = clear
is_signed  in  1  sampled with start: operands signed (1) or unsigned (0)
in_valid  in  1  operand beat valid
in_ready  out  1  high only in LOAD
in_a  in  ROWS*DATA_W  A column vector; lane i at [i*DATA_W +: DATA_W]
in_b  in  COLS*DATA_W  B row vector; lane j at [j*DATA_W +: DATA_W]
out_valid  out  1  result row valid (DRAIN)
out_ready  in  1  sink accepts row
out_row  out  COLS*ACC_W  accumulators of row out_row_idx; col j at [j*ACC_W +: ACC_W]
out_row_idx  out  ROW_IDX_W  row being presented
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after the last row is accepted

Behaviour:
- Reset (asserted low, asynchronous): state IDLE, all accumulators, skew and pass registers 0; in_ready=0, out_valid=0, out_row_idx=0, busy=0, done=0. Reset mid-job aborts the job; no partial output.
- States: IDLE -> LOAD -> FLUSH -> DRAIN -> IDLE.
- IDLE: on start, latch k_len/acc_keep/is_signed; clear accumulators if acc_keep=0. If k_len=0 go to DRAIN; otherwise go to LOAD. start in any other state is ignored.
- Advance: the array (skew registers, pass registers, MACs) updates only on an advance. In LOAD an advance is in_valid&in_ready; in FLUSH every cycle is an advance with zero operands injected. No advance occurs in IDLE or DRAIN, so stalls (in_valid=0) freeze the array exactly.
- Skew: lane i of A is delayed i advances and lane j of B is delayed j advances. Operand pair k reaches PE(i,j) at advance k+i+j. On that advance PE(i,j) performs acc += a*b, with product extended per is_signed, then registers a east and b south.
- LOAD: count accepted beats; after beat k_len go to FLUSH. If ROWS+COLS-2 = 0, go directly to DRAIN.
- FLUSH: exactly ROWS+COLS-2 cycles, then DRAIN. On DRAIN entry, acc(i,j) = previous value (acc_keep) + sum over k of a_k[i]*b_k[j], mod 2^ACC_W.
- DRAIN: out_valid=1, out_row_idx starts at 0 and advances on out_valid&out_ready. out_row is stable while stalled. Accumulators are not modified. When row ROWS-1 is accepted: done=1 for one cycle and the next state is IDLE, where start may be accepted on the following cycle.
- Throughput: one operand beat per cycle in LOAD. Job latency with no stalls, from start to the first out_valid = 1 + k_len + ROWS+COLS-2 cycles.

Decomposition:
- Shared package: state encoding (IDLE, LOAD, FLUSH, DRAIN) and a helper function for the index width (max(1,clog2)).
- One sub-module, os_mac_pe: enable-gated signed/unsigned DATA_W x DATA_W -> ACC_W MAC with a/b pass registers and an accumulator clear.
- Skew delay lines and the FSM stay in the top module.

Test Plan:
- ROWS=COLS=4, k_len=4, A=identity columns, B rows {1,2,3,4}·r -> out_row r = B row r, rows 0..3 in order, done after 4th accept, first out_valid 11 cycles after start.
- Same job with in_valid toggled 1-0-0-1 random -> identical results to unstalled run; in_ready low outside LOAD.
- out_ready held 0 for 5 cycles at row 2 -> out_row/out_row_idx stable, no done, resumes at row 2.
- Job1 k_len=3 all ones, then Job2 acc_keep=1 k_len=2 all ones -> every acc = 5; Job3 acc_keep=0 k_len=0 -> all rows zero immediately.
- is_signed=1, a=0x8000, b=0x8000, k_len=1 -> acc=+2^30; is_signed=0 same operands -> 0x40000000 (2^30); a=0xFFFF,b=0x0002 signed -> acc = -2 (40-bit two's complement).
- Reset pulse low during FLUSH -> outputs zero, busy=0 asynchronously; new job afterwards matches golden model with cleared accumulators.

Source files
------------

// File: rtl/systolic_tile_os_pkg.sv
// Shared definitions for the output-stationary systolic tile.
//   state_e : job sequencer states
//   idx_w   : index width helper, max(1, clog2(n))
package systolic_tile_os_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/systolic_tile_os_mac_pe.sv
// os_mac_pe: one processing element of the output-stationary grid.
//   clk, reset    : clock, asynchronous active-low reset
//   en            : advance; accumulate a_in*b_in and register a/b onward
//   clr_acc       : synchronous accumulator clear (wins over en)
//   clr_pass      : synchronous clear of the a/b pass registers
//   is_signed     : operand interpretation for the product
//   a_in / a_out  : A operand from west / to east
//   b_in / b_out  : B operand from north / to south
//   acc           : accumulator, wraps modulo 2^ACC_W
module os_mac_pe #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr_acc,
    input  logic              clr_pass,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [ACC_W-1:0]  acc
);

    logic [DATA_W-1:0]          a_d, a_q, b_d, b_q;
    logic [ACC_W-1:0]           acc_d, acc_q;
    logic signed [DATA_W:0]     a_ext, b_ext;
    logic signed [2*DATA_W+1:0] prod;
    logic signed [ACC_W-1:0]    prod_acc;

    // One extra bit per operand lets a single signed multiplier serve both
    // modes: the top bit is the sign in signed mode and zero otherwise.
    always_comb begin
        a_ext    = {is_signed & a_in[DATA_W-1], a_in};
        b_ext    = {is_signed & b_in[DATA_W-1], b_in};
        prod     = a_ext * b_ext;
        prod_acc = ACC_W'(prod);
    end

    always_comb begin
        acc_d = acc_q;
        a_d   = a_q;
        b_d   = b_q;
        if (clr_acc) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + prod_acc;
        end
        if (clr_pass) begin
            a_d = '0;
            b_d = '0;
        end else if (en) begin
            a_d = a_in;
            b_d = b_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            a_q   <= a_d;
            b_q   <= b_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

endmodule

// File: rtl/systolic_tile_os.sv
// systolic_tile_os: ROWS x COLS output-stationary integer MAC tile.
//   clk, reset          : clock, asynchronous active-low reset
//   start/k_len/acc_keep/is_signed : job request, sampled in IDLE
//   in_valid/in_ready/in_a/in_b    : operand stream (one A column, one B row per beat)
//   out_valid/out_ready/out_row/out_row_idx : row-serial result drain
//   busy                : job in progress
//   done                : one-cycle pulse after the last row is accepted
// Operands are skewed on entry so pair k meets PE(i,j) on advance k+i+j; the
// array moves only on advances, so input stalls freeze it exactly.
module systolic_tile_os
    import systolic_tile_os_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 40,
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int KLEN_W    = 16,
    parameter int ROW_IDX_W = idx_w(ROWS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [KLEN_W-1:0]      k_len,
    input  logic                   acc_keep,
    input  logic                   is_signed,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ROWS*DATA_W-1:0] in_a,
    input  logic [COLS*DATA_W-1:0] in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COLS*ACC_W-1:0]  out_row,
    output logic [ROW_IDX_W-1:0]   out_row_idx,
    output logic                   busy,
    output logic                   done
);

    localparam int FL   = ROWS + COLS - 2;   // cycles to drain the skew wavefront
    localparam int FL_W = idx_w(FL + 1);

    state_e                state_d, state_q;
    logic [KLEN_W-1:0]     k_len_d, k_len_q;
    logic [KLEN_W-1:0]     beat_d, beat_q;
    logic [FL_W-1:0]       flush_d, flush_q;
    logic [ROW_IDX_W-1:0]  row_d, row_q;
    logic                  sgn_d, sgn_q;
    logic                  done_d, done_q;

    logic adv, take, clr_pipe, clr_acc;

    logic [ROWS-1:0][DATA_W-1:0] inj_a;
    logic [COLS-1:0][DATA_W-1:0] inj_b;
    logic [DATA_W-1:0] a_w [ROWS][COLS+1];
    logic [DATA_W-1:0] b_w [ROWS+1][COLS];
    logic [ROWS-1:0][COLS-1:0][ACC_W-1:0] acc_all;

    assign take     = (state_q == ST_IDLE) && start;
    assign clr_pipe = take;
    assign clr_acc  = take && !acc_keep;
    assign adv      = ((state_q == ST_LOAD) && in_valid) || (state_q == ST_FLUSH);

    // Zeros are injected during FLUSH so the wavefront drains cleanly.
    assign inj_a = (state_q == ST_LOAD) ? in_a : '0;
    assign inj_b = (state_q == ST_LOAD) ? in_b : '0;

    // ---------------- skew delay lines ----------------
    genvar gi, gj;
    for (gi = 0; gi < ROWS; gi++) begin : g_skew_a
        if (gi == 0) begin : g_direct
            assign a_w[0][0] = inj_a[0];
        end else begin : g_dl
            logic [gi-1:0][DATA_W-1:0] dl_d, dl_q;
            always_comb begin
                dl_d = dl_q;
                if (clr_pipe) begin
                    dl_d = '0;
                end else if (adv) begin
                    dl_d[0] = inj_a[gi];
                    for (int s = 1; s < gi; s++) dl_d[s] = dl_q[s-1];
                end
            end
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) dl_q <= '0;
                else        dl_q <= dl_d;
            end
            assign a_w[gi][0] = dl_q[gi-1];
        end
    end

    for (gj = 0; gj < COLS; gj++) begin : g_skew_b
        if (gj == 0) begin : g_direct
            assign b_w[0][0] = inj_b[0];
        end else begin : g_dl
            logic [gj-1:0][DATA_W-1:0] dl_d, dl_q;
            always_comb begin
                dl_d = dl_q;
                if (clr_pipe) begin
                    dl_d = '0;
                end else if (adv) begin
                    dl_d[0] = inj_b[gj];
                    for (int s = 1; s < gj; s++) dl_d[s] = dl_q[s-1];
                end
            end
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) dl_q <= '0;
                else        dl_q <= dl_d;
            end
            assign b_w[0][gj] = dl_q[gj-1];
        end
    end

    // ---------------- PE grid ----------------
    for (gi = 0; gi < ROWS; gi++) begin : g_row
        for (gj = 0; gj < COLS; gj++) begin : g_col
            os_mac_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk       (clk),
                .reset     (reset),
                .en        (adv),
                .clr_acc   (clr_acc),
                .clr_pass  (clr_pipe),
                .is_signed (sgn_q),
                .a_in      (a_w[gi][gj]),
                .b_in      (b_w[gi][gj]),
                .a_out     (a_w[gi][gj+1]),
                .b_out     (b_w[gi+1][gj]),
                .acc       (acc_all[gi][gj])
            );
        end
    end

    // ---------------- sequencer ----------------
    always_comb begin
        state_d = state_q;
        k_len_d = k_len_q;
        beat_d  = beat_q;
        flush_d = flush_q;
        row_d   = row_q;
        sgn_d   = sgn_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    k_len_d = k_len;
                    sgn_d   = is_signed;
                    beat_d  = '0;
                    flush_d = '0;
                    row_d   = '0;
                    state_d = (k_len == '0) ? ST_DRAIN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    if (beat_q == k_len_q - KLEN_W'(1)) begin
                        beat_d  = '0;
                        state_d = (FL == 0) ? ST_DRAIN : ST_FLUSH;
                    end else begin
                        beat_d = beat_q + KLEN_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_q == FL_W'(FL - 1)) begin
                    flush_d = '0;
                    state_d = ST_DRAIN;
                end else begin
                    flush_d = flush_q + FL_W'(1);
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (row_q == ROW_IDX_W'(ROWS - 1)) begin
                        row_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        row_d = row_q + ROW_IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            k_len_q <= '0;
            beat_q  <= '0;
            flush_q <= '0;
            row_q   <= '0;
            sgn_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_len_q <= k_len_d;
            beat_q  <= beat_d;
            flush_q <= flush_d;
            row_q   <= row_d;
            sgn_q   <= sgn_d;
            done_q  <= done_d;
        end
    end

    assign in_ready    = (state_q == ST_LOAD);
    assign out_valid   = (state_q == ST_DRAIN);
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign out_row_idx = row_q;
    assign out_row     = acc_all[row_q];

endmodule
